mc_control_fsm: RTL

- Moore-style multi-cycle MIPS control unit that drives the multi-cycle datapath's control inputs.
- Consumes opcode/funct from the instruction register and the ALU zero flag; produces every datapath enable and select.
- Output names match the datapath control ports one-to-one for direct hookup.
- Adds a retired-instruction counter, a per-instruction done pulse and an illegal-instruction trap.

---
 rtl/mc_control_fsm.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: Moore-style control unit for a multi-cycle MIPS datapath.
// It sequences FETCH/DECODE/execute states from the IR opcode/funct fields,
// drives every datapath enable and select, counts retired instructions,
// and traps (or skips) unsupported opcodes and R-type functs.
module mc_control_fsm #(
  parameter int COUNT_W         = 32,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic               PCWr,
  output logic               Iord,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRwrite,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               RegDst,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSource,
  output logic [2:0]         Operation_ALU,
  output logic [3:0]         state,
  output logic               instr_done,
  output logic               illegal_op,
  output logic [COUNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_TRAP   = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_LW  = 3'b101;
  localparam logic [2:0] ALU_SW  = 3'b110;
  localparam logic [2:0] ALU_BEQ = 3'b111;

  // Returns {legal, alu_op} for an R-type funct field.
  function automatic logic [3:0] decode_funct(input logic [5:0] f);
    case (f)
      6'b100000: return {1'b1, ALU_ADD};
      6'b100010: return {1'b1, ALU_SUB};
      6'b100100: return {1'b1, ALU_AND};
      6'b100101: return {1'b1, ALU_OR};
      6'b100110: return {1'b1, ALU_XOR};
      default:   return {1'b0, ALU_ADD};
    endcase
  endfunction

  state_t               state_r;
  state_t               state_nx;
  state_t               ill_target;
  logic [COUNT_W-1:0]   count_r;
  logic                 illegal_r;
  logic [3:0]           funct_dec;

  logic                 pc_wr_c;
  logic                 iord_c;
  logic                 mem_read_c;
  logic                 mem_write_c;
  logic                 ir_write_c;
  logic                 mem_to_reg_c;
  logic                 reg_write_c;
  logic                 reg_dst_c;
  logic                 alu_src_a_c;
  logic [1:0]           alu_src_b_c;
  logic [1:0]           pc_source_c;
  logic [2:0]           alu_op_c;
  logic                 done_c;

  assign funct_dec = decode_funct(funct);

  // State register, retired-instruction counter and sticky trap flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= S_FETCH;
      count_r   <= '0;
      illegal_r <= 1'b0;
    end else begin
      state_r <= state_nx;
      if (done_c) begin
        count_r <= count_r + COUNT_W'(1);
      end
      if (state_nx == S_TRAP) begin
        illegal_r <= 1'b1;
      end
    end
  end

  // Next-state and Moore output decode; only BRANCH's PCWr looks at zero.
  always_comb begin
    state_nx     = S_FETCH;
    ill_target   = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
    pc_wr_c      = 1'b0;
    iord_c       = 1'b0;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    ir_write_c   = 1'b0;
    mem_to_reg_c = 1'b0;
    reg_write_c  = 1'b0;
    reg_dst_c    = 1'b0;
    alu_src_a_c  = 1'b0;
    alu_src_b_c  = 2'b00;
    pc_source_c  = 2'b00;
    alu_op_c     = ALU_ADD;
    done_c       = 1'b0;
    case (state_r)
      S_FETCH: begin
        mem_read_c  = 1'b1;
        ir_write_c  = 1'b1;
        alu_src_b_c = 2'b01;
        pc_wr_c     = 1'b1;
        state_nx    = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b_c = 2'b11;
        case (opcode)
          OP_RTYPE:     state_nx = S_EXEC;
          OP_LW, OP_SW: state_nx = S_MEMADR;
          OP_BEQ:       state_nx = S_BRANCH;
          OP_ADDI:      state_nx = S_ADDIEX;
          OP_J:         state_nx = S_JUMP;
          default:      state_nx = ill_target;
        endcase
      end
      S_MEMADR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        if (opcode == OP_LW) begin
          alu_op_c = ALU_LW;
          state_nx = S_MEMRD;
        end else begin
          alu_op_c = ALU_SW;
          state_nx = S_MEMWR;
        end
      end
      S_MEMRD: begin
        iord_c     = 1'b1;
        mem_read_c = 1'b1;
        state_nx   = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg_c = 1'b1;
        reg_write_c  = 1'b1;
        done_c       = 1'b1;
      end
      S_MEMWR: begin
        iord_c      = 1'b1;
        mem_write_c = 1'b1;
        done_c      = 1'b1;
      end
      S_EXEC: begin
        alu_src_a_c = 1'b1;
        if (funct_dec[3]) begin
          alu_op_c = funct_dec[2:0];
          state_nx = S_RWB;
        end else begin
          state_nx = ill_target;
        end
      end
      S_RWB: begin
        reg_dst_c   = 1'b1;
        reg_write_c = 1'b1;
        done_c      = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = ALU_BEQ;
        pc_source_c = 2'b01;
        pc_wr_c     = zero;
        done_c      = 1'b1;
      end
      S_JUMP: begin
        pc_source_c = 2'b10;
        pc_wr_c     = 1'b1;
        done_c      = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        state_nx    = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write_c = 1'b1;
        done_c      = 1'b1;
      end
      S_TRAP: begin
        state_nx = S_TRAP;
      end
      default: begin
        state_nx = S_FETCH;
      end
    endcase
  end

  // While reset is held every output reads zero so nothing is written.
  assign PCWr          = pc_wr_c & ~reset;
  assign Iord          = iord_c & ~reset;
  assign MemRead       = mem_read_c & ~reset;
  assign MemWrite      = mem_write_c & ~reset;
  assign IRwrite       = ir_write_c & ~reset;
  assign MemtoReg      = mem_to_reg_c & ~reset;
  assign RegWrite      = reg_write_c & ~reset;
  assign RegDst        = reg_dst_c & ~reset;
  assign ALUSrcA       = alu_src_a_c & ~reset;
  assign ALUSrcB       = reset ? 2'b00 : alu_src_b_c;
  assign PCSource      = reset ? 2'b00 : pc_source_c;
  assign Operation_ALU = reset ? 3'b000 : alu_op_c;
  assign state         = reset ? 4'd0 : state_r;
  assign instr_done    = done_c & ~reset;
  assign illegal_op    = illegal_r & ~reset;
  assign instr_count   = reset ? '0 : count_r;

endmodule
